spi_master: RTL and testbench

- Single-clock SPI master that drives the serial side of the SPI slave: SS_n, MOSI, and MISO capture.
- A host issues one 10-bit command word (cmd[9:8] opcode, cmd[7:0] payload) per transaction.
- For read-data opcodes, the block collects the 8-bit reply from MISO and returns it to the host.
- The SPI shift clock is the system clock `clk`, shared with the slave.

---
 rtl/spi_master.sv | 109 ++++++++++
 tb/tb_spi_master.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-clock SPI master: one 10-bit command per transaction, optional 8-bit read reply
module spi_master #(
  parameter int CMD_W   = 10,
  parameter int RD_W    = 8,
  parameter int RD_WAIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CMD_W-1:0] cmd_word,
  output logic             busy,
  output logic             done,
  output logic [RD_W-1:0]  rd_data,
  output logic             rd_valid,
  output logic             SS_n,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int CNT_MAX = (CMD_W > RD_W) ? ((CMD_W > RD_WAIT) ? CMD_W : RD_WAIT)
                                          : ((RD_W > RD_WAIT) ? RD_W : RD_WAIT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SELECT, SEND, WAIT, RECV, FINISH} state_t;

  state_t           state;
  logic [CMD_W:0]   shift;
  logic [RD_W-1:0]  rd_shift;
  logic [CNT_W-1:0] cnt;
  logic             is_read;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_shift <= '0;
      shift    <= '0;
      cnt      <= '0;
      is_read  <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high in the cycle after FINISH, so a start seen there is dropped
          if (start && !busy) begin
            shift   <= {cmd_word[CMD_W-1], cmd_word};
            is_read <= &cmd_word[CMD_W-1 -: 2];
            busy    <= 1'b1;
            state   <= SELECT;
          end else begin
            busy <= 1'b0;
          end
        end
        SELECT: begin
          SS_n  <= 1'b0;
          MOSI  <= 1'b0;
          cnt   <= CNT_W'(CMD_W);
          state <= SEND;
        end
        SEND: begin
          MOSI  <= shift[CMD_W];
          shift <= {shift[CMD_W-1:0], 1'b0};
          if (cnt == '0) begin
            if (is_read) begin
              cnt   <= CNT_W'(RD_WAIT - 1);
              state <= WAIT;
            end else begin
              state <= FINISH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT: begin
          MOSI <= 1'b0;
          if (cnt == '0) begin
            cnt   <= CNT_W'(RD_W - 1);
            state <= RECV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECV: begin
          rd_shift <= {rd_shift[RD_W-2:0], MISO};
          if (cnt == '0) state <= FINISH;
          else           cnt   <= cnt - 1'b1;
        end
        FINISH: begin
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
          done  <= 1'b1;
          if (is_read) begin
            rd_data  <= rd_shift;
            rd_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed vector bench for spi_master
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] cmd_word;
  logic       busy, done, rd_valid, SS_n, MOSI;
  logic [7:0] rd_data;
  logic       MISO;

  int errors = 0;
  int checks = 0;

  spi_master #(.CMD_W(10), .RD_W(8), .RD_WAIT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_word(cmd_word),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Watches one transaction; k counts edges from the accepting edge (k=1), MISO is driven MSB first from k=15.
  task automatic capture(input logic [7:0] miso_byte, input bit drop_start,
                         output logic [10:0] mosi_bits, output int start_n, output int lat,
                         output int ss_low, output logic rv, output logic [7:0] rdd);
    int k;
    mosi_bits = '0; start_n = 0; lat = 0; ss_low = 0; rv = 1'b0; rdd = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (start_n == 0 && busy) start_n = n;
      if (start_n != 0) begin
        if (drop_start) start = 1'b0;
        k = n - start_n + 1;
        if (k >= 3 && k <= 13) mosi_bits[13-k] = MOSI;
        if (!SS_n) ss_low++;
        if (k >= 15 && k <= 22) MISO = miso_byte[22-k];
        if (done) begin
          lat = k; rv = rd_valid; rdd = rd_data;
          break;
        end
      end
    end
  endtask

  typedef struct {
    logic [9:0]  cmd;
    logic [7:0]  miso;
    logic [10:0] mosi;
    int          lat;
    int          ss;
    logic        rv;
    logic [7:0]  rd;
  } vec_t;

  vec_t        vecs[5];
  logic [10:0] mb;
  int          sn, lat, ssl, dcnt;
  logic        rv;
  logic [7:0]  rdd;
  logic [7:0]  mem[256];
  logic [7:0]  wr_addr, rd_addr;
  logic [9:0]  seq[3];

  initial begin
    vecs[0] = '{10'h0A5, 8'h00, 11'h0A5, 14, 12, 1'b0, 8'h00};
    vecs[1] = '{10'h300, 8'hC3, 11'h700, 24, 22, 1'b1, 8'hC3};
    vecs[2] = '{10'h1FF, 8'h00, 11'h1FF, 14, 12, 1'b0, 8'hC3};
    vecs[3] = '{10'h2AA, 8'h00, 11'h6AA, 14, 12, 1'b0, 8'hC3};
    vecs[4] = '{10'h35A, 8'h5A, 11'h75A, 24, 22, 1'b1, 8'h5A};

    rst = 1'b1; start = 1'b0; cmd_word = '0; MISO = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_ss_n", SS_n, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_mosi", MOSI, 1'b0);
    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_done", done, 1'b0);

    for (int i = 0; i < 5; i++) begin
      cmd_word = vecs[i].cmd;
      start = 1'b1;
      capture(vecs[i].miso, 1'b1, mb, sn, lat, ssl, rv, rdd);
      chk($sformatf("v%0d_mosi", i), mb, vecs[i].mosi);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_ss_low", i), ssl, vecs[i].ss);
      chk($sformatf("v%0d_rd_valid", i), rv, vecs[i].rv);
      chk($sformatf("v%0d_rd_data", i), rdd, vecs[i].rd);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_busy", i), busy, 1'b0);
    end

    // start held high, cmd_word altered mid-send
    cmd_word = 10'h0A5;
    start = 1'b1;
    fork
      capture(8'h00, 1'b0, mb, sn, lat, ssl, rv, rdd);
      begin
        repeat (6) @(posedge clk);
        #2 cmd_word = 10'h3FF;
      end
    join
    chk("hold_first_mosi", mb, 11'h0A5);
    chk("hold_first_latency", lat, 14);
    capture(8'h96, 1'b1, mb, sn, lat, ssl, rv, rdd);
    chk("hold_second_gap", sn, 2);
    chk("hold_second_mosi", mb, 11'h7FF);
    chk("hold_second_latency", lat, 24);
    chk("hold_second_rd_data", rdd, 8'h96);
    repeat (3) @(posedge clk);

    // reset in the middle of SEND
    #1 cmd_word = 10'h0A5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ss_n", SS_n, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rd_data", rd_data, 8'h00);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("midrst_no_done", dcnt, 0);
    cmd_word = 10'h1FF;
    start = 1'b1;
    capture(8'h00, 1'b1, mb, sn, lat, ssl, rv, rdd);
    chk("after_rst_mosi", mb, 11'h1FF);
    chk("after_rst_latency", lat, 14);
    chk("after_rst_ss_low", ssl, 12);
    repeat (3) @(posedge clk);

    // back-to-back loopback through an erased (all-ones) slave memory
    for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
    wr_addr = '0; rd_addr = '0;
    seq[0] = 10'h0FF; seq[1] = 10'h212; seq[2] = 10'h300;
    for (int i = 0; i < 3; i++) begin
      #1 cmd_word = seq[i];
      start = 1'b1;
      capture(mem[rd_addr], 1'b1, mb, sn, lat, ssl, rv, rdd);
      case (mb[9:8])
        2'b00: wr_addr = mb[7:0];
        2'b01: mem[wr_addr] = mb[7:0];
        2'b10: rd_addr = mb[7:0];
        default: ;
      endcase
      if (i > 0) chk($sformatf("b2b%0d_ss_high_gap", i), sn >= 2, 1'b1);
    end
    chk("b2b_rd_data", rdd, 8'hFF);
    chk("b2b_rd_valid", rv, 1'b1);
    chk("b2b_latency", lat, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
